// File: rtl/text_buffer_if.sv
// rtl/text_buffer_if.sv - write-side character handshake between the keyboard/calculator side and text_buffer
interface text_buffer_if;
   logic       i_char_valid;
   logic [6:0] i_char;
   logic       o_char_ready;

   modport master (
      output i_char_valid,
      output i_char,
      input  o_char_ready
   );

   modport slave (
      input  i_char_valid,
      input  i_char,
      output o_char_ready
   );
endinterface

// File: rtl/text_buffer.sv
// rtl/text_buffer.sv - character-cell frame store with cursor, control codes and 1-cycle display read
// Optional macro TEXT_BUFFER_CLEAR_ON_RESET_EN: reset enters CLEAR so memory is zeroed before first use.
module text_buffer #(
   parameter int COLS = 40,
   parameter int ROWS = 30
) (
   input  logic                      pix_clk,
   input  logic                      rst_n,
   text_buffer_if.slave              bus,
   input  logic [11:0]               i_x,
   input  logic [11:0]               i_y,
   output logic [11:0]               o_x,
   output logic [11:0]               o_y,
   output logic [6:0]                o_character,
   output logic [$clog2(COLS)-1:0]   o_cur_col,
   output logic [$clog2(ROWS)-1:0]   o_cur_row
);

   localparam int N  = COLS * ROWS;
   localparam int AW = $clog2(N);
   localparam int CW = $clog2(COLS);
   localparam int RW = $clog2(ROWS);

   localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
   localparam logic [AW-1:0] ADDR_LAST = AW'(N - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

`ifdef TEXT_BUFFER_CLEAR_ON_RESET_EN
   localparam state_t RESET_STATE = CLEAR;
`else
   localparam state_t RESET_STATE = IDLE;
`endif

   function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
      return AW'(int'(r) * COLS + int'(c));
   endfunction

   logic [6:0]    mem [N];

   state_t        state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [RW-1:0] row_inc;

   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [6:0]    wr_data;

   logic [7:0]    x_cell, y_cell;
   logic          in_range;
   logic [AW-1:0] rd_addr;
   logic          unused_pix_bits;

   assign bus.o_char_ready = (state_q == IDLE);
   assign o_cur_col        = col_q;
   assign o_cur_row        = row_q;

   assign row_inc = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      cnt_d   = cnt_q;
      wr_en   = 1'b0;
      wr_addr = cell_addr(row_q, col_q);
      wr_data = bus.i_char;

      unique case (state_q)
         IDLE: begin
            if (bus.i_char_valid) begin
               if (bus.i_char >= 7'h20 && bus.i_char <= 7'h7E) begin
                  wr_en = 1'b1;
                  if (col_q == COL_LAST) begin
                     col_d = '0;
                     row_d = row_inc;
                  end else begin
                     col_d = col_q + 1'b1;
                  end
               end else begin
                  case (bus.i_char)
                     7'h08: begin
                        // Backspace blanks the cell it lands on, wrapping to the end of the previous row.
                        if (col_q != '0) begin
                           col_d   = col_q - 1'b1;
                           wr_en   = 1'b1;
                           wr_addr = cell_addr(row_q, col_q - 1'b1);
                           wr_data = 7'h20;
                        end else if (row_q != '0) begin
                           col_d   = COL_LAST;
                           row_d   = row_q - 1'b1;
                           wr_en   = 1'b1;
                           wr_addr = cell_addr(row_q - 1'b1, COL_LAST);
                           wr_data = 7'h20;
                        end
                     end
                     7'h0D: begin
                        col_d = '0;
                        row_d = row_inc;
                     end
                     7'h0C: begin
                        state_d = CLEAR;
                        cnt_d   = '0;
                     end
                     default: ;
                  endcase
               end
            end
         end
         CLEAR: begin
            wr_en   = 1'b1;
            wr_addr = cnt_q;
            wr_data = 7'h00;
            if (cnt_q == ADDR_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               col_d   = '0;
               row_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase
   end

   // Display side: pixel to cell; off-screen cells render as 0x00.
   assign x_cell          = i_x[11:4];
   assign y_cell          = i_y[11:4];
   assign in_range        = (int'(x_cell) < COLS) && (int'(y_cell) < ROWS);
   assign rd_addr         = AW'(int'(y_cell) * COLS + int'(x_cell));
   assign unused_pix_bits = ^{i_x[3:0], i_y[3:0]};

   always_ff @(posedge pix_clk) begin
      if (!rst_n) begin
         state_q     <= RESET_STATE;
         col_q       <= '0;
         row_q       <= '0;
         cnt_q       <= '0;
         o_x         <= '0;
         o_y         <= '0;
         o_character <= 7'h00;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         cnt_q       <= cnt_d;
         o_x         <= i_x;
         o_y         <= i_y;
         o_character <= in_range ? mem[rd_addr] : 7'h00;
      end
   end

   // Storage is never reset; the read above sees the pre-write value on a same-address collision.
   always_ff @(posedge pix_clk) begin
      if (rst_n && wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

endmodule

// File: tb/tb_text_buffer.sv
// tb/tb_text_buffer.sv - randomized and directed self-checking bench for text_buffer
module tb_text_buffer;

   localparam int COLS = 40;
   localparam int ROWS = 30;
   localparam int N    = COLS * ROWS;

   logic        pix_clk = 1'b0;
   logic        rst_n;
   logic [11:0] i_x, i_y;
   logic [11:0] o_x, o_y;
   logic [6:0]  o_character;
   logic [5:0]  o_cur_col;
   logic [4:0]  o_cur_row;

   text_buffer_if bus ();

   text_buffer #(.COLS(COLS), .ROWS(ROWS)) dut (
      .pix_clk     (pix_clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .i_x         (i_x),
      .i_y         (i_y),
      .o_x         (o_x),
      .o_y         (o_y),
      .o_character (o_character),
      .o_cur_col   (o_cur_col),
      .o_cur_row   (o_cur_row)
   );

   initial forever #5 pix_clk = ~pix_clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      total++;
      bad++;
      $display("FAIL %s: no response within bound at %0t", name, $time);
   endtask

   // Reference model: cursor, cell array with known flags, remaining clear cycles.
   int         m_col, m_row, m_clear_left;
   logic [6:0] m_mem [N];
   bit         m_known [N];
   int         e_x, e_y, e_char;
   bit         e_char_known, e_ready;
   bit         chk_en = 1'b0;
   int         xc, yc, ca;

   initial begin
      for (int i = 0; i < N; i++) m_known[i] = 1'b0;
   end

   task automatic model_char(input int c);
      if (c >= 32 && c <= 126) begin
         m_mem[m_row * COLS + m_col] = 7'(c);
         m_known[m_row * COLS + m_col] = 1'b1;
         m_col++;
         if (m_col == COLS) begin
            m_col = 0;
            m_row = (m_row + 1) % ROWS;
         end
      end else if (c == 8) begin
         if (m_col > 0) begin
            m_col--;
            m_mem[m_row * COLS + m_col] = 7'h20;
            m_known[m_row * COLS + m_col] = 1'b1;
         end else if (m_row > 0) begin
            m_row--;
            m_col = COLS - 1;
            m_mem[m_row * COLS + m_col] = 7'h20;
            m_known[m_row * COLS + m_col] = 1'b1;
         end
      end else if (c == 13) begin
         m_col = 0;
         m_row = (m_row + 1) % ROWS;
      end else if (c == 12) begin
         m_clear_left = N;
      end
   endtask

   initial forever begin
      @(posedge pix_clk);
      if (!rst_n) begin
         m_col = 0;
         m_row = 0;
         e_x = 0;
         e_y = 0;
         e_char = 0;
         e_char_known = 1'b1;
`ifdef TEXT_BUFFER_CLEAR_ON_RESET_EN
         m_clear_left = N;
`else
         m_clear_left = 0;
`endif
      end else begin
         xc = int'(i_x) / 16;
         yc = int'(i_y) / 16;
         if (xc >= COLS || yc >= ROWS) begin
            e_char = 0;
            e_char_known = 1'b1;
         end else begin
            e_char = int'(m_mem[yc * COLS + xc]);
            e_char_known = m_known[yc * COLS + xc];
         end
         e_x = int'(i_x);
         e_y = int'(i_y);
         if (m_clear_left > 0) begin
            ca = N - m_clear_left;
            m_mem[ca] = 7'h00;
            m_known[ca] = 1'b1;
            m_clear_left--;
            if (m_clear_left == 0) begin
               m_col = 0;
               m_row = 0;
            end
         end else if (bus.i_char_valid) begin
            model_char(int'(bus.i_char));
         end
      end
      e_ready = (m_clear_left == 0);
   end

   initial forever begin
      @(negedge pix_clk);
      if (chk_en) begin
         chk("ready", int'(bus.o_char_ready), int'(e_ready));
         chk("cur_col", int'(o_cur_col), m_col);
         chk("cur_row", int'(o_cur_row), m_row);
         chk("o_x", int'(o_x), e_x);
         chk("o_y", int'(o_y), e_y);
         if (e_char_known) chk("o_character", int'(o_character), e_char);
      end
   end

   task automatic rand_pix();
      i_x = 12'($urandom_range(0, 700));
      i_y = 12'($urandom_range(0, 540));
   endtask

   task automatic send(input logic [6:0] c);
      int n = 0;
      @(negedge pix_clk);
      bus.i_char_valid = 1'b1;
      bus.i_char = c;
      rand_pix();
      while (!bus.o_char_ready && n < 3000) begin
         @(negedge pix_clk);
         rand_pix();
         n++;
      end
      if (n >= 3000) timeout("send");
      @(negedge pix_clk);
      bus.i_char_valid = 1'b0;
      rand_pix();
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!bus.o_char_ready && n < 3000) begin
         @(negedge pix_clk);
         rand_pix();
         n++;
      end
      if (n >= 3000) timeout("wait_ready");
   endtask

   task automatic count_low(input string name, input int exp);
      int low = 0;
      while (!bus.o_char_ready && low < 3000) begin
         low++;
         @(negedge pix_clk);
         rand_pix();
      end
      chk(name, low, exp);
   endtask

   task automatic peek(input string name, input int x, input int y, input int exp);
      @(negedge pix_clk);
      i_x = 12'(x);
      i_y = 12'(y);
      @(negedge pix_clk);
      chk(name, int'(o_character), exp);
      chk({name, "_x"}, int'(o_x), x);
   endtask

   task automatic scan_zero(input int cell0);
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            peek("scan", c * 16 + int'($urandom_range(0, 15)), r * 16 + int'($urandom_range(0, 15)),
                 (r == 0 && c == 0) ? cell0 : 0);
   endtask

   function automatic logic [6:0] pick();
      int r = int'($urandom_range(0, 99));
      if (r < 70) return 7'($urandom_range(32, 126));
      if (r < 82) return 7'h08;
      if (r < 90) return 7'h0D;
      if (r < 99) return (r & 1) ? 7'h7F : 7'($urandom_range(14, 31));
      return 7'h0C;
   endfunction

   initial begin
      rst_n = 1'b0;
      bus.i_char_valid = 1'b0;
      bus.i_char = 7'h00;
      i_x = '0;
      i_y = '0;
      repeat (3) @(negedge pix_clk);
      chk_en = 1'b1;
`ifdef TEXT_BUFFER_CLEAR_ON_RESET_EN
      chk("reset_ready", int'(bus.o_char_ready), 0);
`else
      chk("reset_ready", int'(bus.o_char_ready), 1);
`endif
      chk("reset_o_x", int'(o_x), 0);
      chk("reset_o_y", int'(o_y), 0);
      chk("reset_char", int'(o_character), 0);
      chk("reset_col", int'(o_cur_col), 0);
      rst_n = 1'b1;
`ifndef TEXT_BUFFER_CLEAR_ON_RESET_EN
      send(7'h0C);
`endif
      wait_ready();

      send(7'h31); send(7'h32); send(7'h2B); send(7'h33);
      chk("str_col", int'(o_cur_col), 4);
      peek("str_cell0", 0, 0, 'h31);
      peek("str_cell3", 48, 5, 'h33);

      // Form feed with valid held high; the next code rides on the same valid.
      @(negedge pix_clk);
      bus.i_char_valid = 1'b1;
      bus.i_char = 7'h0C;
      @(negedge pix_clk);
      bus.i_char = 7'h41;
      count_low("ff_block_cycles", 1200);
      @(negedge pix_clk);
      bus.i_char_valid = 1'b0;
      @(negedge pix_clk);
      chk("after_ff_col", int'(o_cur_col), 1);
      chk("after_ff_row", int'(o_cur_row), 0);
      scan_zero('h41);

      for (int i = 0; i < 39; i++) send(7'($urandom_range(33, 126)));
      chk("row_wrap_col", int'(o_cur_col), 0);
      chk("row_wrap_row", int'(o_cur_row), 1);
      for (int i = 0; i < 1159; i++) send(7'($urandom_range(33, 126)));
      send(7'h5A);
      chk("full_wrap_col", int'(o_cur_col), 0);
      chk("full_wrap_row", int'(o_cur_row), 0);
      peek("last_cell", 639, 479, 'h5A);
      peek("off_right", 640, 100, 0);
      peek("off_bottom", 100, 480, 0);

      send(7'h08);
      chk("bs00_col", int'(o_cur_col), 0);
      chk("bs00_row", int'(o_cur_row), 0);
      peek("bs00_cell", 5, 5, 'h41);
      send(7'h0D);
      send(7'h08);
      chk("bs01_col", int'(o_cur_col), 39);
      chk("bs01_row", int'(o_cur_row), 0);
      peek("bs01_cell", 39 * 16 + 3, 2, 'h20);

      // Reset in the middle of a clear.
      send(7'h0C);
      repeat (300) @(negedge pix_clk);
      rst_n = 1'b0;
      @(negedge pix_clk);
      rst_n = 1'b1;
`ifdef TEXT_BUFFER_CLEAR_ON_RESET_EN
      chk("midclr_reset_ready", int'(bus.o_char_ready), 0);
      count_low("reset_clear_cycles", 1200);
      scan_zero(0);
`else
      chk("midclr_reset_ready", int'(bus.o_char_ready), 1);
      chk("midclr_reset_col", int'(o_cur_col), 0);
`endif

      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) begin
               @(negedge pix_clk);
               rand_pix();
            end
         end
         send(pick());
      end
      wait_ready();
      repeat (2) @(negedge pix_clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/text_buffer.md
# text_buffer

Character-cell frame store sitting directly upstream of the glyph renderer in the IO_graphics path. It accepts a stream of 7-bit ASCII codes from the calculator/keyboard side over a valid/ready handshake and maintains a cursor with basic control codes. On the display side it converts the current pixel coordinate into a cell address and returns that cell's character. Its outputs `o_x`, `o_y` and `o_character` feed the renderer's `i_x`, `i_y` and `character` inputs, delay-matched.

## Interface
- `COLS`, 40, text columns; 640 px / 16 px glyph width.
- `ROWS`, 30, text rows; 480 px / 16 px glyph height.
- `pix_clk`  in  1  the single clock, shared by the write side and the display side.
- `rst_n`  in  1  synchronous, active-low reset.
- `i_char_valid`  in  1  a write-side character is offered.
- `i_char`  in  7  ASCII code of the offered character.
- `o_char_ready`  out  1  the block can accept a character this cycle.
- `i_x`  in  12  current pixel column from the timing generator.
- `i_y`  in  12  current pixel row from the timing generator.
- `o_x`  out  12  `i_x` delayed by 1 cycle.
- `o_y`  out  12  `i_y` delayed by 1 cycle.
- `o_character`  out  7  character of the cell containing (`o_x`, `o_y`).
- `o_cur_col`  out  $clog2(COLS)  cursor column.
- `o_cur_row`  out  $clog2(ROWS)  cursor row.

## Operation
- Storage: N = COLS*ROWS entries of 7 bits. Address = row*COLS + col.
- Handshake: a character is accepted on a rising edge where `i_char_valid && o_char_ready`.
  - `o_char_ready` = (state == IDLE).
  - Valid may be held high. The code is consumed exactly once per accepting edge.
- Printable codes, 0x20–0x7E:
  - Write the code at the cursor, then advance the column.
  - At col COLS-1: col becomes 0 and row increments.
  - At (COLS-1, ROWS-1): wrap to (0,0). There is no scrolling.
- 0x08, backspace:
  - If col>0: col decrements and 0x20 is written at the new position, in the same cycle.
  - If col==0 and row>0: move to (COLS-1, row-1) and write 0x20 there.
  - At (0,0): no-op.
- 0x0D, carriage return: col becomes 0 and row increments. Row ROWS-1 wraps to 0. No memory write.
- 0x0C, form feed: enter CLEAR.
- Any other code is consumed and ignored; no state change.
- FSM states:
  - IDLE goes to CLEAR on an accepted 0x0C. Otherwise it stays in IDLE.
  - CLEAR writes 0x00 to addresses 0..N-1, one per cycle, using an internal counter.
  - After address N-1 is written, the cursor becomes (0,0) and the FSM returns to IDLE.
- Display read:
  - Each edge latches `i_x`/`i_y` into `o_x`/`o_y`.
  - It loads `o_character` with mem[(i_y>>4)*COLS + (i_x>>4)].
  - If `i_x>>4 >= COLS` or `i_y>>4 >= ROWS`, `o_character` is 0x00 (renders black).
- The read side runs in every state. During CLEAR it shows partially cleared contents.
- A read and a write to the same address on the same edge: the read returns the old value (read-before-write).

## Timing
- Reset values:
  - `o_char_ready` 1 (0 if the macro is defined; see Configuration).
  - `o_x`, `o_y` 0.
  - `o_character` 0x00.
  - `o_cur_col`, `o_cur_row` 0.
  - Clear counter 0.
- Write latency:
  - A character accepted at edge T is visible in memory after T.
  - A read issued at edge T+1 returns it.
  - The cursor outputs update at T.
- Clear:
  - 0x0C is accepted at edge T.
  - `o_char_ready` is 0 after edges T through T+N-1.
  - It is 1 again after edge T+N, with the cursor at (0,0).
  - Total blocked cycles = N (1200 at defaults).
- Display latency is exactly 1 cycle. `o_x`/`o_y`/`o_character` are always mutually consistent.
- Reset mid-operation (including mid-CLEAR) takes effect on the next edge and forces the reset values. Memory contents are not reset except via the macro.

## Configuration
- `TEXT_BUFFER_CLEAR_ON_RESET_EN`
- Defined: reset enters CLEAR instead of IDLE.
  - `o_char_ready` is 0 from the reset edge for N cycles.
  - The full memory is zeroed before the first character is accepted.
- Undefined: reset enters IDLE with `o_char_ready`=1. Memory contents are retained or undefined.

## Test plan
- Write "12+3": `o_cur_col` goes to 4. Pixel (0,0) returns 0x31 one cycle later with `o_x`=0. Pixel (48,5) returns 0x33.
- Write 40 printable characters from (0,0): cursor goes to (0,1). Write 1200 characters: cursor wraps to (0,0).
- Backspace at (0,1): cursor goes to (39,0) and cell (39,0) reads 0x20. Backspace at (0,0): cursor and memory are unchanged.
- Send 0x0C with valid held high: ready is low for exactly 1200 cycles. All cells then read 0x00 and the cursor is (0,0). The following character is accepted once.
- Pixel (640,100) and (100,480): `o_character` is 0x00. Pixel x=639, y=479 reads cell (39,29).
- With the macro defined: assert `rst_n`=0 mid-clear, then release. Ready stays low for 1200 cycles, then all cells read 0x00. Without the macro, ready is 1 on the first cycle after reset.
